// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  localparam logic [31:0] BEGIN_ADDR = 32'h1C00_0000;
  localparam logic [31:0] PC_INC     = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  // Sequential successor of a fetch address; wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] addr);
    return addr + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry valid/ready skid between the imem response and decode, with flush.
module fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        pop,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        free
);

  logic        valid_r;
  logic [31:0] inst_r;
  logic [31:0] pc_r;

  // Entry state: flush wins over load, load wins over pop (load and pop may coincide).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      inst_r  <= 32'd0;
      pc_r    <= 32'd0;
    end else begin
      if (flush) begin
        valid_r <= 1'b0;
      end else if (load) begin
        valid_r <= 1'b1;
      end else if (pop) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
      if (load && !flush) begin
        inst_r <= load_inst;
        pc_r   <= load_pc;
      end
    end
  end

  assign valid = valid_r;
  assign inst  = inst_r;
  assign pc    = pc_r;
  assign free  = !valid_r || pop;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: drives the PC register, one outstanding imem request, and the decode buffer.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_en,
  output logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  fetch_state_e state_r, state_s;
  logic         kill_r, kill_s;
  logic [31:0]  req_addr_r, req_addr_s;

  logic         redirect_s;
  logic [31:0]  redirect_target_s;
  logic         seq_en_s;
  logic         buf_load_s;
  logic         buf_free_s;

  // Exception redirect takes priority over a branch in the same cycle.
  always_comb begin
    redirect_s = exc_valid | br_valid;
    if (exc_valid) begin
      redirect_target_s = exc_target;
    end else begin
      redirect_target_s = br_target;
    end
  end

  // Next-state logic; kill marks the in-flight response as stale after a redirect.
  always_comb begin
    state_s    = state_r;
    kill_s     = kill_r;
    req_addr_s = req_addr_r;
    seq_en_s   = 1'b0;
    buf_load_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (buf_free_s && !redirect_s) begin
          state_s    = REQ;
          req_addr_s = pc;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // A redirect never abandons the handshake; the address stays put until gnt.
        if (imem_gnt) begin
          state_s  = WAIT;
          seq_en_s = !kill_r && !redirect_s;
        end else begin
          state_s = REQ;
        end
        if (redirect_s) begin
          kill_s = 1'b1;
        end else begin
          kill_s = kill_r;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_r || redirect_s) begin
            kill_s = 1'b0;
            if (redirect_s) begin
              state_s = IDLE;
            end else if (buf_free_s) begin
              state_s    = REQ;
              req_addr_s = pc;
            end else begin
              state_s = IDLE;
            end
          end else begin
            buf_load_s = 1'b1;
            state_s    = IDLE;
          end
        end else begin
          if (redirect_s) begin
            kill_s = 1'b1;
          end else begin
            kill_s = kill_r;
          end
        end
      end
      default: begin
        state_s    = IDLE;
        kill_s     = 1'b0;
        req_addr_s = 32'd0;
      end
    endcase
  end

  // PC register controls: redirect overrides the sequential step taken at grant.
  always_comb begin
    pc_en = redirect_s | seq_en_s;
    if (redirect_s) begin
      npc = redirect_target_s;
    end else begin
      npc = seq_pc(req_addr_r);
    end
  end

  // FSM, kill flag and request address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      kill_r     <= 1'b0;
      req_addr_r <= 32'd0;
    end else begin
      state_r    <= state_s;
      kill_r     <= kill_s;
      req_addr_r <= req_addr_s;
    end
  end

  assign imem_req  = (state_r == REQ);
  assign imem_addr = req_addr_r;

  fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load_s),
    .flush     (redirect_s),
    .pop       (id_ready),
    .load_inst (imem_rdata),
    .load_pc   (req_addr_r),
    .valid     (if_valid),
    .inst      (if_inst),
    .pc        (if_pc),
    .free      (buf_free_s)
  );

endmodule
